// File: rtl/four_phase_checker_pkg.sv
// four_phase_checker_pkg: FSM states, phase indices and error-cause bits shared by the
// four-phase clock checker.
package four_phase_checker_pkg;
    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_e;
    localparam logic [1:0] PH1 = 2'd0;
    localparam logic [1:0] PH2 = 2'd1;
    localparam logic [1:0] PH3 = 2'd2;
    localparam logic [1:0] PH4 = 2'd3;
    localparam int ERR_ORDER = 0;
    localparam int ERR_OVERLAP = 1;
    localparam int ERR_P23 = 2;
    localparam int ERR_STALL = 3;
    localparam int ERR_W = 4;
    function automatic logic [1:0] phase_of(input logic [3:0] ph);
        return ph[0] ? PH1 : ph[1] ? PH2 : ph[2] ? PH3 : PH4;
    endfunction
endpackage

// File: rtl/four_phase_checker_sync2.sv
// sync2: generic 2-flop synchronizer with asynchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q_o, meta_q} <= 2'b00;
        else {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/four_phase_checker.sv
// four_phase_checker: oversamples P1..P4/P23, checks order, overlap and P23 consistency,
// reports lock, rotation strobes and a saturating error count. Stall check: FOUR_PHASE_STALL_EN.
module four_phase_checker
    import four_phase_checker_pkg::*;
#(
    parameter int LOCK_CYCLES = 4,
    parameter int CNT_W = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             P1,
    input  logic             P2,
    input  logic             P3,
    input  logic             P4,
    input  logic             P23,
    output logic [1:0]       phase_idx,
    output logic             phase_valid,
    output logic             rot_strobe,
    output logic             locked,
    output logic             seq_err,
    output logic [CNT_W-1:0] err_count
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    state_e state_q, state_d;
    logic [3:0] rot_q, rot_d, rot_inc;
    logic [1:0] phase_idx_q, phase_idx_d, idx;
    logic phase_valid_q, rot_strobe_q, rot_strobe_d, locked_q, seq_err_q, seq_err_d, err_prev_q;
    logic [CNT_W-1:0] err_count_q;
    logic [4:0] lines, sync;
    logic [3:0] ph;
    logic gap, valid, active, trans, wrap, err, stall;
    logic [ERR_W-1:0] err_c;

    assign lines = {P23, P4, P3, P2, P1};
    for (genvar i = 0; i < 5; i++) begin : g_sync
        sync2 u_sync (.clk(clk), .rst(rst), .d_i(lines[i]), .q_o(sync[i]));
    end

    assign ph = sync[3:0];
    assign gap = ph == 4'd0;
    assign valid = !gap && (ph & (ph - 4'd1)) == 4'd0;
    assign idx = phase_of(ph);
    assign active = state_q != HUNT;
    assign trans = valid && idx != phase_idx_q;
    assign wrap = trans && phase_idx_q == PH4 && idx == PH1;
    assign err_c[ERR_ORDER] = active && trans && idx != phase_idx_q + 2'd1;
    assign err_c[ERR_OVERLAP] = !gap && !valid;
    assign err_c[ERR_P23] = valid ? sync[4] != (ph[1] | ph[2]) : gap && sync[4];
    assign err_c[ERR_STALL] = stall;
    assign err = |err_c;
    // A fault that persists over several samples is a single error event.
    assign seq_err_d = err && !err_prev_q;
    assign rot_inc = rot_q + 4'd1;

`ifdef FOUR_PHASE_STALL_EN
    logic [HOLD_W-1:0] hold_q;
    assign stall = active && !trans && hold_q == HOLD_W'(MAX_HOLD - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) hold_q <= '0;
        else hold_q <= (!active || trans) ? '0 : hold_q + HOLD_W'(1);
`else
    logic [HOLD_W-1:0] unused_hold;
    assign unused_hold = '0;
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rot_d = rot_q;
        rot_strobe_d = 1'b0;
        phase_idx_d = valid ? idx : phase_idx_q;
        if (err) begin
            state_d = HUNT;
            rot_d = '0;
        end else if (!active) begin
            if (valid && idx == PH1) begin
                state_d = TRACK;
                rot_d = '0;
            end
        end else if (wrap) begin
            rot_strobe_d = 1'b1;
            if (state_q == TRACK) begin
                rot_d = rot_inc;
                if (rot_inc == 4'(LOCK_CYCLES)) state_d = LOCKED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            rot_q <= '0;
            phase_idx_q <= '0;
            phase_valid_q <= 1'b0;
            rot_strobe_q <= 1'b0;
            locked_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_prev_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q <= state_d;
            rot_q <= rot_d;
            phase_idx_q <= phase_idx_d;
            phase_valid_q <= valid;
            rot_strobe_q <= rot_strobe_d;
            locked_q <= state_q == LOCKED;
            seq_err_q <= seq_err_d;
            err_prev_q <= err;
            if (seq_err_d && !(&err_count_q)) err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign phase_idx = phase_idx_q;
    assign phase_valid = phase_valid_q;
    assign rot_strobe = rot_strobe_q;
    assign locked = locked_q;
    assign seq_err = seq_err_q;
    assign err_count = err_count_q;
endmodule
